// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - pixel frame buffer with bounds-checked write/read ports and a full-frame fill engine
// Read port is registered and read-first; the fill engine owns the write port while busy.
module frame_buffer #(
  parameter int Width     = 320,
  parameter int Height    = 240,
  parameter int ColorBits = 3,
  parameter int XBits     = 9,
  parameter int YBits     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 WriteEn,
  input  logic [XBits-1:0]     XWrite,
  input  logic [YBits-1:0]     YWrite,
  input  logic [ColorBits-1:0] WriteValue,
  output logic                 WriteReady,
  input  logic                 ReadEn,
  input  logic [XBits-1:0]     XRead,
  input  logic [YBits-1:0]     YRead,
  output logic [ColorBits-1:0] ReadValue,
  output logic                 ReadValid,
  output logic                 ReadOOB,
  input  logic                 FillStart,
  input  logic [ColorBits-1:0] FillValue,
  output logic                 FillBusy,
  output logic                 FillDone
);

  localparam int Depth    = Width * Height;
  localparam int AddrBits = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrBits-1:0] LastAddr = AddrBits'(Depth - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [AddrBits-1:0]  fill_cnt_q;
  logic [ColorBits-1:0] fill_color_q;
  logic                 fill_busy_q;
  logic                 fill_done_q;

  logic [ColorBits-1:0] rd_value_q;
  logic                 rd_valid_q;
  logic                 rd_oob_q;

  logic [ColorBits-1:0] mem [Depth];

  logic                 wr_in_range;
  logic                 rd_in_range;
  logic [AddrBits-1:0]  wr_addr;
  logic [AddrBits-1:0]  rd_addr;

  logic                 mem_we;
  logic [AddrBits-1:0]  mem_waddr;
  logic [ColorBits-1:0] mem_wdata;

  assign wr_in_range = (32'(XWrite) < 32'(Width)) && (32'(YWrite) < 32'(Height));
  assign rd_in_range = (32'(XRead) < 32'(Width)) && (32'(YRead) < 32'(Height));
  assign wr_addr     = AddrBits'(32'(YWrite) * 32'(Width) + 32'(XWrite));
  assign rd_addr     = AddrBits'(32'(YRead) * 32'(Width) + 32'(XRead));

  // Single write port: the fill engine has priority; nothing lands during reset so an
  // aborted fill leaves exactly the pixels written before the reset edge.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = WriteValue;
    if (rst_n) begin
      if (state_q == FILL) begin
        mem_we    = 1'b1;
        mem_waddr = fill_cnt_q;
        mem_wdata = fill_color_q;
      end else if ((state_q == IDLE) && WriteEn && wr_in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_value_q <= '0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      rd_valid_q <= ReadEn;
      rd_oob_q   <= ReadEn && !rd_in_range;
      if (ReadEn) begin
        rd_value_q <= rd_in_range ? mem[rd_addr] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fill_cnt_q   <= '0;
      fill_color_q <= '0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (FillStart) begin
            state_q      <= FILL;
            fill_cnt_q   <= '0;
            fill_color_q <= FillValue;
            fill_busy_q  <= 1'b1;
          end
        end
        FILL: begin
          fill_cnt_q <= fill_cnt_q + AddrBits'(1);
          if (fill_cnt_q == LastAddr) begin
            state_q     <= DONE;
            fill_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          fill_busy_q <= 1'b0;
          fill_done_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign WriteReady = (state_q == IDLE);
  assign ReadValue  = rd_value_q;
  assign ReadValid  = rd_valid_q;
  assign ReadOOB    = rd_oob_q;
  assign FillBusy   = fill_busy_q;
  assign FillDone   = fill_done_q;

endmodule
